qs_partition_unit: RTL

//  Lomuto partition engine for the quick-sort datapath. Consumes the 5-bit index

---
 rtl/qs_pkg.sv | 14 +
 rtl/qs_swap_regfile.sv | 42 ++++
 rtl/qs_partition_unit.sv | 134 +++++++++++++
 3 files changed

// File: rtl/qs_pkg.sv
// Shared types and sizes for the quick-sort datapath: partition FSM states
// and the element/index widths also used by the index counter and sort control.
package qs_pkg;
    localparam int QS_DATA_W = 8;
    localparam int QS_IDX_W  = 5;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_PIVOT,
        SCAN,
        FINAL,
        DONE
    } qs_state_e;
endpackage

// File: rtl/qs_swap_regfile.sv
// Element array: two async read ports feed a same-cycle swap through two write
// ports; a third, registered read port serves external readback.
module qs_swap_regfile #(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 5
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [IDX_W-1:0]  i_ra_addr,
    output logic [DATA_W-1:0] o_ra_data,
    input  logic [IDX_W-1:0]  i_rb_addr,
    output logic [DATA_W-1:0] o_rb_data,
    input  logic              i_wa_en,
    input  logic [IDX_W-1:0]  i_wa_addr,
    input  logic [DATA_W-1:0] i_wa_data,
    input  logic              i_wb_en,
    input  logic [IDX_W-1:0]  i_wb_addr,
    input  logic [DATA_W-1:0] i_wb_data,
    input  logic [IDX_W-1:0]  i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);
    localparam int DEPTH = 1 << IDX_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    assign o_ra_data = r_mem[i_ra_addr];
    assign o_rb_data = r_mem[i_rb_addr];
    assign o_rd_data = r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
            r_rd_data <= '0;
        end else begin
            // Port B is written last so it wins on an address collision.
            if (i_wa_en) r_mem[i_wa_addr] <= i_wa_data;
            if (i_wb_en) r_mem[i_wb_addr] <= i_wb_data;
            r_rd_data <= r_mem[i_rd_addr];
        end
    end
endmodule

// File: rtl/qs_partition_unit.sv
// Lomuto partition engine: partitions arr[lo..hi] around arr[hi], one element per clock.
// Optional swap counter output enabled by defining QS_PART_STATS_EN.
module qs_partition_unit
    import qs_pkg::*;
#(
    parameter int DATA_W = QS_DATA_W,
    parameter int IDX_W  = QS_IDX_W
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wr_en,
    input  logic [IDX_W-1:0]  i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [IDX_W-1:0]  i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    input  logic              i_start,
    input  logic [IDX_W-1:0]  i_lo,
    input  logic [IDX_W-1:0]  i_hi,
    output logic              o_busy,
    output logic              o_done,
    output logic [IDX_W-1:0]  o_pivot_idx
`ifdef QS_PART_STATS_EN
    ,output logic [IDX_W:0]   o_swap_cnt
`endif
);
    qs_state_e         r_state, w_next;
    logic [IDX_W-1:0]  r_i, r_j, r_hi, r_pivot_idx;
    logic [DATA_W-1:0] r_pivot;

    logic [IDX_W-1:0]  w_ra_addr, w_wa_addr, w_wb_addr;
    logic [DATA_W-1:0] w_ra_data, w_rb_data, w_wa_data, w_wb_data;
    logic              w_wa_en, w_wb_en, w_lt, w_start_ok, w_range;

    assign w_start_ok = (r_state == IDLE) && i_start;
    assign w_range    = i_lo < i_hi;
    // Port A reads arr[j] while scanning, arr[hi] otherwise; port B always reads arr[i].
    assign w_ra_addr  = (r_state == SCAN) ? r_j : r_hi;
    assign w_lt       = w_ra_data < r_pivot;

    qs_swap_regfile #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_rf (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_ra_addr (w_ra_addr),
        .o_ra_data (w_ra_data),
        .i_rb_addr (r_i),
        .o_rb_data (w_rb_data),
        .i_wa_en   (w_wa_en),
        .i_wa_addr (w_wa_addr),
        .i_wa_data (w_wa_data),
        .i_wb_en   (w_wb_en),
        .i_wb_addr (w_wb_addr),
        .i_wb_data (w_wb_data),
        .i_rd_addr (i_rd_addr),
        .o_rd_data (o_rd_data)
    );

    always_comb begin
        w_next    = r_state;
        w_wa_en   = 1'b0;
        w_wa_addr = r_i;
        w_wa_data = w_ra_data;
        w_wb_en   = 1'b0;
        w_wb_addr = w_ra_addr;
        w_wb_data = w_rb_data;
        case (r_state)
            IDLE: begin
                w_wa_en   = i_wr_en;
                w_wa_addr = i_wr_addr;
                w_wa_data = i_wr_data;
                if (i_start) w_next = w_range ? LOAD_PIVOT : DONE;
            end
            LOAD_PIVOT: w_next = SCAN;
            SCAN: begin
                w_wa_en = w_lt;
                w_wb_en = w_lt;
                if (r_j == r_hi - IDX_W'(1)) w_next = FINAL;
            end
            FINAL: begin
                w_wa_en = 1'b1;
                w_wb_en = 1'b1;
                w_next  = DONE;
            end
            DONE: begin
                w_wa_en   = i_wr_en;
                w_wa_addr = i_wr_addr;
                w_wa_data = i_wr_data;
                w_next    = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_i         <= '0;
            r_j         <= '0;
            r_hi        <= '0;
            r_pivot     <= '0;
            r_pivot_idx <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: if (w_start_ok) begin
                    r_i  <= i_lo;
                    r_j  <= i_lo;
                    r_hi <= i_hi;
                    if (!w_range) r_pivot_idx <= i_lo;
                end
                LOAD_PIVOT: r_pivot <= w_ra_data;
                SCAN: begin
                    r_j <= r_j + IDX_W'(1);
                    if (w_lt) r_i <= r_i + IDX_W'(1);
                end
                FINAL: r_pivot_idx <= r_i;
                default: ;
            endcase
        end
    end

`ifdef QS_PART_STATS_EN
    logic [IDX_W:0] r_swap_cnt;
    always_ff @(posedge i_clk) begin
        if (i_reset)                      r_swap_cnt <= '0;
        else if (w_start_ok)              r_swap_cnt <= '0;
        else if (r_state == SCAN && w_lt) r_swap_cnt <= r_swap_cnt + (IDX_W+1)'(1);
    end
    assign o_swap_cnt = r_swap_cnt;
`endif

    assign o_busy      = (r_state == LOAD_PIVOT) || (r_state == SCAN) || (r_state == FINAL);
    assign o_done      = (r_state == DONE);
    assign o_pivot_idx = r_pivot_idx;
endmodule
